// File: rtl/beep_pkg.sv
// Shared constants for the beep sequencer: state encoding, pattern table, counter widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package beep_pkg;

  // Sequencer states
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BEEP = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  // Tick counter holds up to 500 ticks; beep counter holds up to 3 beeps.
  localparam int TICK_W = 9;
  localparam int BEEP_W = 2;

  // Pattern table, indexed by pattern number (element [0] is the rightmost entry).
  //                                         pat3    pat2    pat1    pat0
  localparam logic [3:0][TICK_W-1:0] ON_T  = {9'd100, 9'd500, 9'd100, 9'd100};
  localparam logic [3:0][TICK_W-1:0] OFF_T = {9'd100, 9'd0,   9'd100, 9'd0};
  localparam logic [3:0][BEEP_W-1:0] COUNT = {2'd3,   2'd1,   2'd2,   2'd1};

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every DIV cycles; clr restarts the count so the next tick is DIV cycles away.
// Latency: tick is a decode of the registered count (high in the DIV-th cycle after clr).
// Backpressure: none; free-running.
// Ports: clk, rst_n (async active-low), clr (synchronous restart), tick (output pulse).
module tick_gen #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/beep_sequencer.sv
// Plays one of four beep patterns (ON/OFF/COUNT in ticks) on a registered buzzer enable.
// Latency: buzzer_en/busy rise one cycle after start is accepted; done marks the last pattern cycle.
// Backpressure: start is ignored while busy; cancel aborts at once and wins over start.
// Ports: clk, rst_n (async active-low), start + pattern[1:0] (request), cancel (abort),
//        buzzer_en (registered buzzer enable), busy (pattern in progress), done (completion pulse).
module beep_sequencer
  import beep_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 1000000,
  parameter int TICK_HZ     = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] pattern,
  input  logic       cancel,
  output logic       buzzer_en,
  output logic       busy,
  output logic       done
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;

  logic [1:0]        state;
  logic [1:0]        pat;
  logic [TICK_W-1:0] tick_cnt;
  logic [TICK_W-1:0] phase_len;
  logic [BEEP_W-1:0] remain;
  logic              tick;
  logic              accept;
  logic              phase_end;
  logic              last_beep;

  // Accepting only from IDLE is what makes a retrigger while busy a no-op.
  assign accept    = start && !cancel && (state == IDLE);
  assign phase_len = (state == GAP) ? OFF_T[pat] : ON_T[pat];
  // phase_end lands on the edge that closes exactly phase_len*DIV cycles of the phase.
  assign phase_end = tick && (tick_cnt == phase_len - TICK_W'(1));
  assign last_beep = (remain == BEEP_W'(1));
  // done is the final cycle of the last beep, so busy still covers it; the pattern
  // drops busy on the same edge as buzzer_en. A cancel in that cycle suppresses it.
  assign done      = (state == BEEP) && phase_end && last_beep && !cancel;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pat       <= 2'd0;
      tick_cnt  <= '0;
      remain    <= '0;
      buzzer_en <= 1'b0;
      busy      <= 1'b0;
    end else if (cancel) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      remain    <= '0;
      buzzer_en <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pat       <= pattern;
            state     <= BEEP;
            tick_cnt  <= '0;
            remain    <= COUNT[pattern];
            buzzer_en <= 1'b1;
            busy      <= 1'b1;
          end
        end
        BEEP: begin
          if (phase_end) begin
            tick_cnt  <= '0;
            buzzer_en <= 1'b0;
            remain    <= remain - BEEP_W'(1);
            if (last_beep) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= GAP;
            end
          end else if (tick) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        GAP: begin
          if (phase_end) begin
            tick_cnt  <= '0;
            buzzer_en <= 1'b1;
            state     <= BEEP;
          end else if (tick) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          buzzer_en <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beep_sequencer.sv
// Bench for beep_sequencer with a 10-cycle tick (CLK_FREQ_HZ=10000, TICK_HZ=1000).
// A timeline model predicts busy/buzzer_en/done every cycle; directed scenarios add literal totals.
// Inputs change 2 time units after the rising edge; outputs are compared on the falling edge.
module tb_beep_sequencer;

  localparam int DIV = 10;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] pattern;
  logic       cancel;
  logic       buzzer_en;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  beep_sequencer #(
    .CLK_FREQ_HZ (10000),
    .TICK_HZ     (1000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pattern   (pattern),
    .cancel    (cancel),
    .buzzer_en (buzzer_en),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pattern table in ticks.
  int on_tbl  [4] = '{100, 100, 500, 100};
  int off_tbl [4] = '{0,   100, 0,   100};
  int cnt_tbl [4] = '{1,   2,   1,   3};

  // Timeline model: a pattern accepted on edge t0 occupies cycles k = 0 .. L-1 after it.
  int m_cyc    = 0;
  int m_t0     = 0;
  int m_pat    = 0;
  bit m_active = 1'b0;

  function automatic int pat_len(input int p);
    return (cnt_tbl[p] * on_tbl[p] + (cnt_tbl[p] - 1) * off_tbl[p]) * DIV;
  endfunction

  function automatic bit e_busy();
    int k;
    k = m_cyc - m_t0;
    return m_active && (k < pat_len(m_pat));
  endfunction

  function automatic bit e_buzz();
    int k;
    k = m_cyc - m_t0;
    return e_busy() && (((k / DIV) % (on_tbl[m_pat] + off_tbl[m_pat])) < on_tbl[m_pat]);
  endfunction

  function automatic bit e_done(input logic cancel_now);
    int k;
    k = m_cyc - m_t0;
    return m_active && (k == pat_len(m_pat) - 1) && !cancel_now;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit busy_now;
    if (!rst_n) begin
      m_active = 1'b0;
    end else begin
      busy_now = e_busy();
      m_cyc    = m_cyc + 1;
      if (cancel) begin
        m_active = 1'b0;
      end else if (start && !busy_now) begin
        m_active = 1'b1;
        m_t0     = m_cyc;
        m_pat    = int'(pattern);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("model_busy", int'(busy), int'(e_busy()));
    chk("model_buzzer_en", int'(buzzer_en), int'(e_buzz()));
    chk("model_done", int'(done), int'(e_done(cancel)));
  end

  // Cycle totals for the literal checks.
  int hi_cnt = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (buzzer_en === 1'b1) hi_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic clr_meas();
    hi_cnt   = 0;
    busy_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(input logic [1:0] p);
    @(posedge clk); #2;
    start   = 1'b1;
    pattern = p;
    @(posedge clk); #2;
    start   = 1'b0;
  endtask

  initial begin
    bit found;
    rst_n   = 1'b0;
    start   = 1'b0;
    cancel  = 1'b0;
    pattern = 2'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_buzzer_en", int'(buzzer_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    run(20);
    chk("idle_after_rst", int'(busy), 0);

    // A: pattern 0 -> one 100-tick beep
    clr_meas();
    pulse_start(2'd0);
    @(negedge clk);
    chk("A_en_rise", int'(buzzer_en), 1);
    chk("A_busy_rise", int'(busy), 1);
    run(1100);
    chk("A_hi_cycles", hi_cnt, 1000);
    chk("A_busy_cycles", busy_cnt, 1000);
    chk("A_done_pulses", done_cnt, 1);
    chk("A_busy_end", int'(busy), 0);

    // B: pattern 3 -> beep/gap x3, last gap omitted
    clr_meas();
    pulse_start(2'd3);
    run(5100);
    chk("B_hi_cycles", hi_cnt, 3000);
    chk("B_busy_cycles", busy_cnt, 5000);
    chk("B_done_pulses", done_cnt, 1);

    // C: retrigger during pattern 2 is ignored
    clr_meas();
    pulse_start(2'd2);
    run(2000);
    pulse_start(2'd3);
    run(3100);
    chk("C_hi_cycles", hi_cnt, 5000);
    chk("C_busy_cycles", busy_cnt, 5000);
    chk("C_done_pulses", done_cnt, 1);

    // D: cancel in cycle 1500 of pattern 1 (inside the gap)
    clr_meas();
    pulse_start(2'd1);
    repeat (1500) @(posedge clk);
    #2;
    cancel = 1'b1;
    @(posedge clk); #2;
    cancel = 1'b0;
    @(negedge clk);
    chk("D_busy_drop", int'(busy), 0);
    chk("D_en_low", int'(buzzer_en), 0);
    run(2000);
    chk("D_hi_cycles", hi_cnt, 1000);
    chk("D_busy_cycles", busy_cnt, 1501);
    chk("D_done_pulses", done_cnt, 0);

    // E: asynchronous reset mid-beep
    pulse_start(2'd0);
    repeat (500) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("E_en_async", int'(buzzer_en), 0);
    chk("E_busy_async", int'(busy), 0);
    chk("E_done_async", int'(done), 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    clr_meas();
    run(1500);
    chk("E_busy_after", busy_cnt, 0);
    chk("E_done_after", done_cnt, 0);

    // F: start+cancel while idle does nothing; start right after done is accepted
    clr_meas();
    @(posedge clk); #2;
    start  = 1'b1;
    cancel = 1'b1;
    @(posedge clk); #2;
    start  = 1'b0;
    cancel = 1'b0;
    run(50);
    chk("F_no_activity", busy_cnt, 0);
    pulse_start(2'd0);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("F_done_seen", int'(found), 1);
    chk("F_busy_in_done", int'(busy), 1);
    @(posedge clk); #2;
    start   = 1'b1;
    pattern = 2'd1;
    clr_meas();
    @(posedge clk); #2;
    start   = 1'b0;
    @(negedge clk);
    chk("F_restart_en", int'(buzzer_en), 1);
    chk("F_restart_busy", int'(busy), 1);
    run(3100);
    chk("F_hi_cycles", hi_cnt, 2000);
    chk("F_busy_cycles", busy_cnt, 3000);
    chk("F_done_pulses", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
